// File: rtl/main_fsm.sv
// Next-state sequencer for the RV32I multicycle core: state register feeding the control
// decoder, plus retire/illegal pulses and the instret/cycle counters.
module main_fsm #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instr,
   output logic [4:0]       state,
   output logic             retire,
   output logic             illegal_instr,
   output logic             illegal_seen,
   output logic [CNT_W-1:0] instret,
   output logic [CNT_W-1:0] cycle
);

   typedef enum logic [4:0] {
      StFetch  = 5'd0,
      StDecode = 5'd1,
      StMemAdr = 5'd2,
      StMemRd  = 5'd3,
      StLoadWb = 5'd4,
      StMemWr  = 5'd5,
      StRExec  = 5'd6,
      StRWb    = 5'd7,
      StBeq    = 5'd8,
      StIExec  = 5'd9,
      StIWb    = 5'd10,
      StJal    = 5'd11,
      StJalr   = 5'd12,
      StBne    = 5'd13,
      StBlt    = 5'd14,
      StBge    = 5'd15,
      StBltu   = 5'd16,
      StBgeu   = 5'd17,
      StAuipc  = 5'd18,
      StLui    = 5'd19
   } state_e;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpReg    = 7'b0110011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpBranch = 7'b1100011;

   state_e           state_q, state_d;
   logic             retire_q, retire_d;
   logic             illegal_q, illegal_d;
   logic             seen_q, seen_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic [CNT_W-1:0] cycle_q, cycle_d;

   logic [6:0] opcode;
   logic [2:0] funct3;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];

   always_comb begin
      state_d   = StFetch;
      retire_d  = 1'b0;
      illegal_d = 1'b0;
      case (state_q)
         StFetch: state_d = StDecode;
         StDecode: begin
            case (opcode)
               OpLoad, OpStore: state_d = StMemAdr;
               OpReg:           state_d = StRExec;
               OpImm:           state_d = StIExec;
               OpJal:           state_d = StJal;
               OpJalr:          state_d = StJalr;
               OpAuipc:         state_d = StAuipc;
               OpLui:           state_d = StLui;
               OpBranch: begin
                  case (funct3)
                     3'b000:  state_d = StBeq;
                     3'b001:  state_d = StBne;
                     3'b100:  state_d = StBlt;
                     3'b101:  state_d = StBge;
                     3'b110:  state_d = StBltu;
                     3'b111:  state_d = StBgeu;
                     default: illegal_d = 1'b1;
                  endcase
               end
               default: illegal_d = 1'b1;
            endcase
         end
         StMemAdr: state_d = (opcode == OpLoad) ? StMemRd : StMemWr;
         StMemRd:  state_d = StLoadWb;
         StRExec:  state_d = StRWb;
         StIExec:  state_d = StIWb;
         StLoadWb, StMemWr, StRWb, StBeq, StIWb, StJal, StJalr,
         StBne, StBlt, StBge, StBltu, StBgeu, StAuipc, StLui: retire_d = 1'b1;
         // Unreachable encodings fall back to Fetch silently.
         default: state_d = StFetch;
      endcase
   end

   assign seen_d    = seen_q | illegal_d;
   assign instret_d = instret_q + CNT_W'(retire_d);
   assign cycle_d   = cycle_q + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StFetch;
         retire_q  <= 1'b0;
         illegal_q <= 1'b0;
         seen_q    <= 1'b0;
         instret_q <= '0;
         cycle_q   <= '0;
      end else begin
         state_q   <= state_d;
         retire_q  <= retire_d;
         illegal_q <= illegal_d;
         seen_q    <= seen_d;
         instret_q <= instret_d;
         cycle_q   <= cycle_d;
      end
   end

   assign state         = state_q;
   assign retire        = retire_q;
   assign illegal_instr = illegal_q;
   assign illegal_seen  = seen_q;
   assign instret       = instret_q;
   assign cycle         = cycle_q;

endmodule

// File: tb/tb_main_fsm.sv
// Directed bench for main_fsm: instruction-class state walks, illegal decode, mid-instruction
// reset, and counter wrap on a narrow-counter instance sharing the same stimulus.
module tb_main_fsm;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr;

   logic [4:0]  state, state4;
   logic        retire, retire4;
   logic        illegal_instr, illegal_instr4;
   logic        illegal_seen, illegal_seen4;
   logic [31:0] instret, cycle;
   logic [3:0]  instret4, cycle4;

   int compares = 0;
   int fails    = 0;
   int exp_cycle;
   int exp_instret;
   logic exp_seen;

   always #5 clk = ~clk;

   main_fsm #(.CNT_W(32)) dut (
      .clk(clk), .reset(reset), .instr(instr), .state(state), .retire(retire),
      .illegal_instr(illegal_instr), .illegal_seen(illegal_seen), .instret(instret),
      .cycle(cycle)
   );

   main_fsm #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .instr(instr), .state(state4), .retire(retire4),
      .illegal_instr(illegal_instr4), .illegal_seen(illegal_seen4), .instret(instret4),
      .cycle(cycle4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compares++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      exp_cycle++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_cycle   = 0;
      exp_instret = 0;
      exp_seen    = 1'b0;
      check("rst_state", {27'd0, state}, 32'd0);
      check("rst_retire", {31'd0, retire}, 32'd0);
      check("rst_illegal", {31'd0, illegal_instr}, 32'd0);
      check("rst_seen", {31'd0, illegal_seen}, 32'd0);
      check("rst_instret", instret, 32'd0);
      check("rst_cycle", cycle, 32'd0);
      check("rst_cycle4", {28'd0, cycle4}, 32'd0);
   endtask

   // Starts in Fetch; seq holds the states after each edge, first state in the low bits.
   task automatic run_seq(input string tag, input logic [31:0] ins, input int len,
                          input logic [39:0] seq, input logic is_illegal);
      instr = ins;
      for (int i = 0; i < len; i++) begin
         tick();
         check({tag, "_state"}, {27'd0, state}, {27'd0, seq[5*i +: 5]});
      end
      if (is_illegal) exp_seen = 1'b1;
      else exp_instret++;
      check({tag, "_retire"}, {31'd0, retire}, {31'd0, ~is_illegal});
      check({tag, "_illegal"}, {31'd0, illegal_instr}, {31'd0, is_illegal});
      check({tag, "_seen"}, {31'd0, illegal_seen}, {31'd0, exp_seen});
      check({tag, "_instret"}, instret, exp_instret);
      check({tag, "_cycle"}, cycle, exp_cycle);
      check({tag, "_instret4"}, {28'd0, instret4}, exp_instret & 15);
      check({tag, "_cycle4"}, {28'd0, cycle4}, exp_cycle & 15);
   endtask

   logic [31:0] br;
   logic [4:0]  br_tgt [6];
   logic [2:0]  br_f3 [6];

   initial begin
      reset       = 1'b0;
      instr       = 32'h0000_0013;
      exp_cycle   = 0;
      exp_instret = 0;
      exp_seen    = 1'b0;
      do_reset();

      run_seq("lw", 32'h0000_2083, 5, {15'd0, 5'd0, 5'd4, 5'd3, 5'd2, 5'd1}, 1'b0);
      check("lw_cycle_at_retire", cycle, 32'd5);
      tick();
      check("lw_next_state", {27'd0, state}, 32'd1);
      check("lw_next_instret", instret, 32'd1);
      check("lw_next_cycle", cycle, 32'd6);
      check("lw_retire_drops", {31'd0, retire}, 32'd0);
      // Finish that Decode back to Fetch via an illegal word so the walk realigns.
      instr = 32'h0000_0073;
      tick();
      exp_seen = 1'b1;
      check("sys_state", {27'd0, state}, 32'd0);
      check("sys_illegal", {31'd0, illegal_instr}, 32'd1);
      check("sys_seen", {31'd0, illegal_seen}, 32'd1);
      check("sys_no_retire", {31'd0, retire}, 32'd0);
      check("sys_instret", instret, 32'd1);

      run_seq("sw", 32'h0011_2023, 4, {20'd0, 5'd0, 5'd5, 5'd2, 5'd1}, 1'b0);
      run_seq("add", 32'h0020_81B3, 4, {20'd0, 5'd0, 5'd7, 5'd6, 5'd1}, 1'b0);
      run_seq("addi", 32'h0010_8093, 4, {20'd0, 5'd0, 5'd10, 5'd9, 5'd1}, 1'b0);

      br_f3  = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
      br_tgt = '{5'd8, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17};
      for (int i = 0; i < 6; i++) begin
         br = 32'h0020_8063 | ({29'd0, br_f3[i]} << 12);
         run_seq("branch", br, 3, {25'd0, 5'd0, br_tgt[i], 5'd1}, 1'b0);
      end
      run_seq("br_f3_010", 32'h0020_A063, 2, {30'd0, 5'd0, 5'd1}, 1'b1);
      run_seq("br_f3_011", 32'h0020_B063, 2, {30'd0, 5'd0, 5'd1}, 1'b1);
      run_seq("bad_opcode", 32'h0000_007F, 2, {30'd0, 5'd0, 5'd1}, 1'b1);

      run_seq("jal", 32'h0080_00EF, 3, {25'd0, 5'd0, 5'd11, 5'd1}, 1'b0);
      run_seq("jalr", 32'h0000_80E7, 3, {25'd0, 5'd0, 5'd12, 5'd1}, 1'b0);
      run_seq("auipc", 32'h0000_1097, 3, {25'd0, 5'd0, 5'd18, 5'd1}, 1'b0);
      run_seq("lui", 32'h0000_10B7, 3, {25'd0, 5'd0, 5'd19, 5'd1}, 1'b0);

      // Reset while a load sits in MemRd: the load must vanish without counting.
      instr = 32'h0000_2083;
      tick();
      tick();
      tick();
      check("pre_rst_state", {27'd0, state}, 32'd3);
      check("pre_rst_seen", {31'd0, illegal_seen}, 32'd1);
      do_reset();
      run_seq("post_rst_add", 32'h0020_81B3, 4, {20'd0, 5'd0, 5'd7, 5'd6, 5'd1}, 1'b0);
      check("post_rst_instret", instret, 32'd1);

      do_reset();
      for (int n = 0; n < 16; n++) begin
         run_seq("wrap_add", 32'h0020_81B3, 4, {20'd0, 5'd0, 5'd7, 5'd6, 5'd1}, 1'b0);
      end
      check("wrap_instret32", instret, 32'd16);
      check("wrap_cycle32", cycle, 32'd64);
      check("wrap_instret4", {28'd0, instret4}, 32'd0);
      check("wrap_cycle4", {28'd0, cycle4}, 32'd0);
      check("wrap_retire4", {31'd0, retire4}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
      $finish;
   end

endmodule
